vectored_irq_controller: RTL and testbench
==========================================

# vectored_irq_controller

Parametrised, vectored successor to the Zeus 8-source interrupt controller. It aggregates up to 32 active-low interrupt sources, each configurable as level- or edge-sensitive. Edge events are latched in write-1-to-clear pending registers, and a priority encoder presents the winning source index to the CPU. It sits on the peripheral data bus behind a chip select and drives the single active-low CPU IRQ line.

## Interface
- NUM_SOURCES, 16: number of interrupt sources; legal range 1..32.
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- cs_n  in  1  chip select, active-low
- phi2  in  1  bus clock phase; writes are qualified by phi2 high
- write_enable  in  1  bus write cycle
- address  in  5  address[4:2] selects the register, address[1:0] selects the byte lane (sources 8*lane..8*lane+7)
- data_in  in  8  write data
- data_out  out  8  read data, combinational from address
- irq_sources_n  in  NUM_SOURCES  asynchronous interrupt requests, active-low
- irq_out_n  out  1  registered CPU IRQ, active-low

## Operation
- Write strobe: `!cs_n && write_enable && phi2`, sampled on posedge clk. Every register write is idempotent, so a strobe held for several clk cycles is harmless.
- Register map (address[4:2]):
  - 0 STATUS: RO synchronised raw source state, active-high.
  - 1 ENABLE: RW.
  - 2 MODE: RW; 0 = level, 1 = falling-edge.
  - 3 PENDING: read; write-1-to-clear.
  - 4 VECTOR: RO; bits[4:0] give the lowest pending&enabled source index, bit7 = 1 when none, bits[6:5] = 0.
  - 5 ACK: WO; data_in[4:0] selects a source index and its pending bit is cleared.
  - 6, 7: read 0, writes ignored.
- Bits at or above NUM_SOURCES read 0 and ignore writes. A lane value of 1..3 on VECTOR/ACK has no special meaning: VECTOR reads the same on every lane, and ACK acts on every lane.
- Synchroniser: each source passes through 2 flops, reset to 1 (inactive). active = ~sync2.
- Level source: pending <= active each cycle. W1C and ACK have no lasting effect on a level source.
- Edge source: pending is set on a 1→0 transition of sync2 (falling edge of the source). It is cleared by W1C or ACK.
- Simultaneous set and clear on the same source: set wins, so no event is lost.
- A MODE write that changes a bit clears that source's pending bit in the same cycle. From the next cycle the source follows its new mode.
- Priority: the lowest index wins. ENABLE gates both VECTOR and irq_out_n. PENDING reports all sources regardless of ENABLE.
- irq_out_n <= ~|(pending & enable), registered.
- Reset: ENABLE = 0, MODE = 0, PENDING = 0, sync flops = 1, irq_out_n = 1. data_out then reads 0 for every register except VECTOR, which reads 0x80.

## Timing
- Source assertion to irq_out_n low:
  - Edge 1: sync1 samples the source.
  - Edge 2: sync2.
  - Edge 3: pending.
  - Edge 4: irq_out_n.
- The 4-edge latency applies to both modes.
- Level source deassertion: irq_out_n returns high 4 edges after the source deasserts, provided no other source is pending and enabled.
- A write (ENABLE, W1C, ACK) takes effect on the strobed edge. irq_out_n reflects it one edge later.
- data_out follows the current register state combinationally, with no read latency. Reads have no side effects.
- reset_n low on any edge overrides every write and event in that cycle.

## Structure
- Package `irq_pkg`:
  - Register offsets: REG_STATUS..REG_ACK.
  - IRQ_MAX_SOURCES = 32.
  - IRQ_VEC_NONE = 8'h80.
  - typedef `irq_vec_t` (logic [4:0]).
- Sub-module `irq_priority_encoder`: parameter N; input req[N-1:0]; outputs idx (irq_vec_t) and valid. Purely combinational, with the lowest index winning.
- The top level holds the synchronisers, edge detection, register file, bus decode and output flop.

## Test plan
- Reset, NUM_SOURCES=16 → irq_out_n=1, every register reads 0x00, VECTOR reads 0x80.
- Source 3, level, ENABLE lane0=0x08; assert irq_sources_n[3]=0 → irq_out_n low on edge 4 and VECTOR=0x03. Deassert the source → irq_out_n high 4 edges later.
- Source 9 edge mode (MODE lane1=0x02, ENABLE lane1=0x02); pulse source low 3 cycles then release → PENDING lane1=0x02 holds. Write PENDING lane1=0x02 → irq_out_n high 1 edge later.
- Sources 5 and 12, both edge and enabled, fire together → VECTOR=0x05. ACK 5 → VECTOR=0x0C. ACK 12 → VECTOR=0x80, irq_out_n=1.
- A new falling edge on source 9 lands in the same cycle as a W1C of bit 9 → PENDING bit 9 stays 1.
- NUM_SOURCES=20: write 0xFF to ENABLE lane2 → reads back 0x0F. Writes to lane3 and to registers 6/7 → read 0x00. reset_n low mid-pending → all state cleared on that edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller: register offsets,
// source limits and the vector index type.
package irq_pkg;

   localparam int unsigned IRQ_MAX_SOURCES = 32;
   localparam logic [7:0]  IRQ_VEC_NONE    = 8'h80;

   typedef logic [4:0] irq_vec_t;

   // Register select decoded from address[4:2]; offsets 6 and 7 are unused.
   typedef enum logic [2:0] {
      REG_STATUS  = 3'd0,
      REG_ENABLE  = 3'd1,
      REG_MODE    = 3'd2,
      REG_PENDING = 3'd3,
      REG_VECTOR  = 3'd4,
      REG_ACK     = 3'd5
   } irq_reg_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: reports the lowest set request index.
module irq_priority_encoder
   import irq_pkg::*;
#(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0] req,
   output irq_vec_t     idx,
   output logic         valid
);

   // Scan upward and keep the first hit so the lowest index wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !valid) begin
            idx   = irq_vec_t'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vectored_irq_controller.sv
// Vectored interrupt controller: synchronises active-low sources, latches
// level/edge events into pending bits, and presents the lowest enabled
// pending source on the bus and the registered CPU IRQ line.
module vectored_irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned NUM_SOURCES = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cs_n,
   input  logic                   phi2,
   input  logic                   write_enable,
   input  logic [4:0]             address,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   input  logic [NUM_SOURCES-1:0] irq_sources_n,
   output logic                   irq_out_n
);

   logic [NUM_SOURCES-1:0] sync1_q, sync2_q, hist_q;
   logic [NUM_SOURCES-1:0] enable_q, mode_q, pending_q;
   logic [NUM_SOURCES-1:0] enable_d, mode_d, pending_d;
   logic [NUM_SOURCES-1:0] active, fall, armed;
   logic [NUM_SOURCES-1:0] lane_hit, wr_val, ack_hit, clr, mode_chg;
   logic [NUM_SOURCES-1:0] rd_src;
   logic [31:0]            rd_word;
   logic                   wr_strobe;
   logic [1:0]             lane;
   irq_reg_e               reg_sel;
   irq_vec_t               vec_idx;
   logic                   vec_valid;

   assign wr_strobe = !cs_n && write_enable && phi2;
   assign reg_sel   = irq_reg_e'(address[4:2]);
   assign lane      = address[1:0];

   assign active = ~sync2_q;
   // hist_q holds the previous sync2 value, so a 1->0 step of sync2 is an edge.
   assign fall   = hist_q & ~sync2_q;
   assign armed  = pending_q & enable_q;

   irq_priority_encoder #(.N(NUM_SOURCES)) u_prio (
      .req   (armed),
      .idx   (vec_idx),
      .valid (vec_valid)
   );

   // Per-source byte-lane select, write data bit and ACK index match.
   always_comb begin
      lane_hit = '0;
      wr_val   = '0;
      ack_hit  = '0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
         lane_hit[i] = (i[4:3] == lane);
         wr_val[i]   = data_in[i[2:0]];
         ack_hit[i]  = (data_in[4:0] == i[4:0]);
      end
   end

   // Register-file next state: bus writes, clears and pending update rules.
   always_comb begin
      enable_d  = enable_q;
      mode_d    = mode_q;
      clr       = '0;
      pending_d = '0;
      if (wr_strobe) begin
         case (reg_sel)
            REG_ENABLE:  enable_d = (enable_q & ~lane_hit) | (wr_val & lane_hit);
            REG_MODE:    mode_d   = (mode_q & ~lane_hit) | (wr_val & lane_hit);
            REG_PENDING: clr      = lane_hit & wr_val;
            REG_ACK:     clr      = ack_hit;
            default:     ;
         endcase
      end
      mode_chg = mode_d ^ mode_q;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
         if (mode_chg[i])
            pending_d[i] = 1'b0;
         else if (!mode_q[i])
            pending_d[i] = active[i];
         else
            pending_d[i] = fall[i] | (pending_q[i] & ~clr[i]);
      end
   end

   // Read mux: pick the register, zero-extend to 32 bits, select the byte lane.
   always_comb begin
      rd_src  = '0;
      rd_word = '0;
      case (reg_sel)
         REG_STATUS:  rd_src = active;
         REG_ENABLE:  rd_src = enable_q;
         REG_MODE:    rd_src = mode_q;
         REG_PENDING: rd_src = pending_q;
         default:     rd_src = '0;
      endcase
      rd_word[NUM_SOURCES-1:0] = rd_src;
      case (lane)
         2'd0:    data_out = rd_word[7:0];
         2'd1:    data_out = rd_word[15:8];
         2'd2:    data_out = rd_word[23:16];
         default: data_out = rd_word[31:24];
      endcase
      if (reg_sel == REG_VECTOR)
         data_out = vec_valid ? {3'b000, vec_idx} : IRQ_VEC_NONE;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         hist_q    <= '1;
         enable_q  <= '0;
         mode_q    <= '0;
         pending_q <= '0;
         irq_out_n <= 1'b1;
      end else begin
         sync1_q   <= irq_sources_n;
         sync2_q   <= sync1_q;
         hist_q    <= sync2_q;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         pending_q <= pending_d;
         irq_out_n <= ~|armed;
      end
   end

endmodule

// File: tb/tb_vectored_irq_controller.sv
// Self-checking bench for vectored_irq_controller (16- and 20-source builds).
module tb_vectored_irq_controller;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs16_n = 1'b1;
   logic        cs20_n = 1'b1;
   logic        phi2 = 1'b0;
   logic        write_enable = 1'b0;
   logic [4:0]  address = '0;
   logic [7:0]  data_in = '0;
   logic [15:0] src16 = '1;
   logic [19:0] src20 = '1;
   logic [7:0]  data_out16, data_out20;
   logic        irq16, irq20;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   // Reference model state (16-source DUT)
   logic [15:0] m_en, m_mode, m_pend;
   logic        m_irq;
   logic [15:0] hist [3];   // source samples taken 1, 2, 3 edges ago

   vectored_irq_controller #(.NUM_SOURCES(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .cs_n(cs16_n), .phi2(phi2),
      .write_enable(write_enable), .address(address), .data_in(data_in),
      .data_out(data_out16), .irq_sources_n(src16), .irq_out_n(irq16)
   );

   vectored_irq_controller #(.NUM_SOURCES(20)) dut20 (
      .clk(clk), .reset_n(reset_n), .cs_n(cs20_n), .phi2(phi2),
      .write_enable(write_enable), .address(address), .data_in(data_in),
      .data_out(data_out20), .irq_sources_n(src20), .irq_out_n(irq20)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [4:0] a);
      logic [31:0] w, sh;
      w = '0;
      case (a[4:2])
         3'd0: w[15:0] = ~hist[1];
         3'd1: w[15:0] = m_en;
         3'd2: w[15:0] = m_mode;
         3'd3: w[15:0] = m_pend;
         3'd4: begin
            for (int i = 0; i < 16; i++)
               if (m_pend[i] && m_en[i]) return 8'(i);
            return 8'h80;
         end
         default: w = '0;
      endcase
      sh = w >> (8 * a[1:0]);
      return sh[7:0];
   endfunction

   // Advance the model across one clock edge using the current bus/source inputs.
   task automatic model_step();
      logic [31:0] lm32, wv32;
      logic [15:0] lm, wv, act, fall, clr, new_mode, new_pend;
      logic        strobe;
      logic [2:0]  sel;
      if (!reset_n) begin
         m_en = '0; m_mode = '0; m_pend = '0; m_irq = 1'b1;
         for (int k = 0; k < 3; k++) hist[k] = '1;
         return;
      end
      strobe = !cs16_n && write_enable && phi2;
      sel    = address[4:2];
      lm32   = 32'hFF << (8 * address[1:0]);
      wv32   = {24'd0, data_in} << (8 * address[1:0]);
      lm = lm32[15:0];
      wv = wv32[15:0];
      act  = ~hist[1];
      fall = hist[2] & ~hist[1];
      clr  = '0;
      if (strobe && sel == 3'd3) clr = wv & lm;
      if (strobe && sel == 3'd5 && data_in[4:0] < 5'd16) clr[data_in[3:0]] = 1'b1;
      new_mode = (strobe && sel == 3'd2) ? ((m_mode & ~lm) | (wv & lm)) : m_mode;
      for (int i = 0; i < 16; i++) begin
         if (new_mode[i] != m_mode[i]) new_pend[i] = 1'b0;
         else if (!m_mode[i])          new_pend[i] = act[i];
         else                          new_pend[i] = fall[i] | (m_pend[i] & ~clr[i]);
      end
      m_irq = ((m_pend & m_en) == 16'd0);
      if (strobe && sel == 3'd1) m_en = (m_en & ~lm) | (wv & lm);
      m_mode = new_mode;
      m_pend = new_pend;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = src16;
   endtask

   // One clock: check the read path, step the model, then check the IRQ line.
   task automatic cycle();
      #1 check("rd_model", data_out16, model_read(address));
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("irq_model", irq16, m_irq);
   endtask

   task automatic wr16(input logic [4:0] a, input logic [7:0] d);
      cs16_n = 1'b0; write_enable = 1'b1; phi2 = 1'b1; address = a; data_in = d;
      cycle();
      cs16_n = 1'b1; write_enable = 1'b0; phi2 = 1'b0;
   endtask

   task automatic wr20(input logic [4:0] a, input logic [7:0] d);
      cs20_n = 1'b0; write_enable = 1'b1; phi2 = 1'b1; address = a; data_in = d;
      cycle();
      cs20_n = 1'b1; write_enable = 1'b0; phi2 = 1'b0;
   endtask

   task automatic rd16(input string tag, input logic [4:0] a, input logic [7:0] exp);
      address = a;
      #1 check(tag, data_out16, exp);
   endtask

   task automatic rd20(input string tag, input logic [4:0] a, input logic [7:0] exp);
      address = a;
      #1 check(tag, data_out20, exp);
   endtask

   initial begin
      m_en = '0; m_mode = '0; m_pend = '0; m_irq = 1'b1;
      for (int k = 0; k < 3; k++) hist[k] = '1;
      @(negedge clk);

      // Reset state
      reset_n = 1'b0;
      cycle(); cycle();
      reset_n = 1'b1;
      check("reset_irq", irq16, 1'b1);
      for (int a = 0; a < 32; a++) begin
         logic [4:0] aa;
         aa = 5'(a);
         rd16("reset_reg", aa, (aa[4:2] == 3'd4) ? 8'h80 : 8'h00);
      end

      // Level source 3: 4-edge assert and deassert latency
      wr16(5'd4, 8'h08);
      src16[3] = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         cycle();
         check("lvl_assert_irq", irq16, (e == 4) ? 1'b0 : 1'b1);
      end
      rd16("lvl_vector", 5'd16, 8'h03);
      src16[3] = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         cycle();
         check("lvl_deassert_irq", irq16, (e == 4) ? 1'b1 : 1'b0);
      end
      wr16(5'd4, 8'h00);

      // Edge source 9: pulse latches, W1C clears, IRQ follows one edge later
      wr16(5'd9, 8'h02);
      wr16(5'd5, 8'h02);
      src16[9] = 1'b0;
      repeat (3) cycle();
      src16[9] = 1'b1;
      repeat (4) cycle();
      rd16("edge_pending", 5'd13, 8'h02);
      check("edge_irq_low", irq16, 1'b0);
      wr16(5'd13, 8'h02);
      check("w1c_irq_same_edge", irq16, 1'b0);
      rd16("w1c_pending", 5'd13, 8'h00);
      cycle();
      check("w1c_irq_next_edge", irq16, 1'b1);

      // Sources 5 and 12 simultaneous edges, ACK in priority order
      wr16(5'd8, 8'h20);
      wr16(5'd9, 8'h12);
      wr16(5'd4, 8'h20);
      wr16(5'd5, 8'h12);
      src16[5] = 1'b0; src16[12] = 1'b0;
      repeat (2) cycle();
      src16[5] = 1'b1; src16[12] = 1'b1;
      repeat (4) cycle();
      rd16("vec_both", 5'd16, 8'h05);
      rd16("vec_both_lane3", 5'd19, 8'h05);
      wr16(5'd20, 8'd5);
      rd16("vec_after_ack5", 5'd16, 8'h0C);
      wr16(5'd23, 8'd12);
      rd16("vec_after_ack12", 5'd16, 8'h80);
      cycle();
      check("irq_after_acks", irq16, 1'b1);

      // New edge on source 9 coinciding with a W1C of bit 9: set wins
      src16[9] = 1'b0;
      repeat (2) cycle();
      wr16(5'd13, 8'h02);
      rd16("set_beats_w1c", 5'd13, 8'h02);
      src16[9] = 1'b1;
      repeat (3) cycle();
      wr16(5'd13, 8'h02);

      // Randomised traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset_n      = ($urandom_range(0, 199) != 0);
         cs16_n       = ($urandom_range(0, 2) == 0);
         write_enable = $urandom_range(0, 1) == 1;
         phi2         = $urandom_range(0, 1) == 1;
         address      = 5'($urandom);
         data_in      = 8'($urandom);
         for (int b = 0; b < 16; b++)
            if ($urandom_range(0, 7) == 0) src16[b] = ~src16[b];
         cycle();
      end
      cs16_n = 1'b1; write_enable = 1'b0; phi2 = 1'b0; reset_n = 1'b1;
      src16 = '1;

      // 20-source build: unimplemented bits, unused lanes/registers, reset
      wr20(5'd6, 8'hFF);
      rd20("n20_en_lane2", 5'd6, 8'h0F);
      wr20(5'd7, 8'hFF);
      rd20("n20_en_lane3", 5'd7, 8'h00);
      wr20(5'd24, 8'hFF);
      rd20("n20_reg6", 5'd24, 8'h00);
      wr20(5'd28, 8'hFF);
      rd20("n20_reg7", 5'd28, 8'h00);
      wr20(5'd8, 8'h01);
      wr20(5'd4, 8'h01);
      src20[0] = 1'b0;
      repeat (2) cycle();
      src20[0] = 1'b1;
      repeat (3) cycle();
      rd20("n20_pending", 5'd12, 8'h01);
      check("n20_irq_low", irq20, 1'b0);
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      check("n20_reset_irq", irq20, 1'b1);
      rd20("n20_reset_pend", 5'd12, 8'h00);
      rd20("n20_reset_en0", 5'd4, 8'h00);
      rd20("n20_reset_en2", 5'd6, 8'h00);
      rd20("n20_reset_mode", 5'd8, 8'h00);
      rd20("n20_reset_vec", 5'd16, 8'h80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
